// File: rtl/aes_key_fetch_ctrl.sv
// AES request sequencer: fetches a 128-bit key (with a one-entry address cache),
// launches the AES core, waits for completion with a timeout and publishes the result.
module aes_key_fetch_ctrl #(
  parameter int CORE_TIMEOUT = 255,
  parameter int KEY_STRIDE   = 4
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         aes_start,
  input  logic [31:0]  data0_i,
  input  logic [31:0]  data1_i,
  input  logic [31:0]  data2_i,
  input  logic [31:0]  data3_i,
  input  logic [31:0]  key_addr_i,
  output logic         mem_req,
  output logic [31:0]  mem_addr,
  input  logic         mem_ack,
  input  logic [31:0]  mem_rdata,
  output logic         core_start,
  output logic [127:0] core_block,
  output logic [127:0] core_key,
  input  logic         core_done,
  input  logic [127:0] core_result,
  output logic [31:0]  res0_o,
  output logic [31:0]  res1_o,
  output logic [31:0]  res2_o,
  output logic [31:0]  res3_o,
  output logic         aes_done,
  output logic         aes_err,
  output logic         busy
);

  localparam int CW = $clog2(CORE_TIMEOUT + 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CORE_GO,
    S_CORE_WAIT,
    S_DONE
  } state_t;

  state_t         state_reg;
  logic [127:0]   block_reg;
  logic [127:0]   key_reg;
  logic [31:0]    key_addr_reg;
  logic [31:0]    cached_addr_reg;
  logic           key_valid_reg;
  logic [1:0]     idx_reg;
  logic [CW-1:0]  cnt_reg;
  logic [127:0]   res_reg;
  logic           mem_req_reg;
  logic           core_start_reg;
  logic           aes_done_reg;
  logic           aes_err_reg;
  logic           busy_reg;
  logic [31:0]    fetch_addr;

  // Byte address of the current key word; wraps modulo 2^32, low bits forced to word alignment.
  assign fetch_addr = key_addr_reg + 32'(KEY_STRIDE) * {30'd0, idx_reg};

  assign mem_req    = mem_req_reg;
  assign mem_addr   = mem_req_reg ? {fetch_addr[31:2], 2'b00} : 32'd0;
  assign core_start = core_start_reg;
  assign core_block = block_reg;
  assign core_key   = key_reg;
  assign res0_o     = res_reg[127:96];
  assign res1_o     = res_reg[95:64];
  assign res2_o     = res_reg[63:32];
  assign res3_o     = res_reg[31:0];
  assign aes_done   = aes_done_reg;
  assign aes_err    = aes_err_reg;
  assign busy       = busy_reg;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_reg       <= S_IDLE;
      block_reg       <= '0;
      key_reg         <= '0;
      key_addr_reg    <= '0;
      cached_addr_reg <= '0;
      key_valid_reg   <= 1'b0;
      idx_reg         <= '0;
      cnt_reg         <= '0;
      res_reg         <= '0;
      mem_req_reg     <= 1'b0;
      core_start_reg  <= 1'b0;
      aes_done_reg    <= 1'b0;
      aes_err_reg     <= 1'b0;
      busy_reg        <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (aes_start) begin
            block_reg    <= {data0_i, data1_i, data2_i, data3_i};
            key_addr_reg <= key_addr_i;
            busy_reg     <= 1'b1;
            if (key_valid_reg && (key_addr_i == cached_addr_reg)) begin
              core_start_reg <= 1'b1;
              state_reg      <= S_CORE_GO;
            end else begin
              key_valid_reg <= 1'b0;
              idx_reg       <= '0;
              mem_req_reg   <= 1'b1;
              state_reg     <= S_FETCH;
            end
          end
        end

        S_FETCH: begin
          if (mem_ack) begin
            case (idx_reg)
              2'd0:    key_reg[127:96] <= mem_rdata;
              2'd1:    key_reg[95:64]  <= mem_rdata;
              2'd2:    key_reg[63:32]  <= mem_rdata;
              default: key_reg[31:0]   <= mem_rdata;
            endcase
            idx_reg <= idx_reg + 2'd1;
            if (idx_reg == 2'd3) begin
              mem_req_reg     <= 1'b0;
              key_valid_reg   <= 1'b1;
              cached_addr_reg <= key_addr_reg;
              core_start_reg  <= 1'b1;
              state_reg       <= S_CORE_GO;
            end
          end
        end

        S_CORE_GO: begin
          core_start_reg <= 1'b0;
          cnt_reg        <= '0;
          state_reg      <= S_CORE_WAIT;
        end

        S_CORE_WAIT: begin
          // A completion on the same edge as the timeout wins.
          if (core_done) begin
            res_reg      <= core_result;
            aes_done_reg <= 1'b1;
            aes_err_reg  <= 1'b0;
            state_reg    <= S_DONE;
          end else if (cnt_reg + CW'(1) == CW'(CORE_TIMEOUT)) begin
            cnt_reg       <= cnt_reg + CW'(1);
            key_valid_reg <= 1'b0;
            aes_done_reg  <= 1'b1;
            aes_err_reg   <= 1'b1;
            state_reg     <= S_DONE;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end

        S_DONE: begin
          aes_done_reg <= 1'b0;
          aes_err_reg  <= 1'b0;
          busy_reg     <= 1'b0;
          state_reg    <= S_IDLE;
        end

        default: begin
          mem_req_reg    <= 1'b0;
          core_start_reg <= 1'b0;
          aes_done_reg   <= 1'b0;
          aes_err_reg    <= 1'b0;
          busy_reg       <= 1'b0;
          state_reg      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/aes_key_fetch_ctrl.md
AES_KEY_FETCH_CTRL -- requirements
Module: aes_key_fetch_ctrl

Interface
REQ-001 Parameter CORE_TIMEOUT, default 255, is the max cycles waited for core_done before abort.
REQ-002 Parameter KEY_STRIDE, default 4, is the byte increment between key word addresses.
REQ-003 clk  input  1  clock; all state on rising edge.
REQ-004 nrst  input  1  reset, asynchronous, active-low.
REQ-005 aes_start  input  1  one-cycle request from CSR side.
REQ-006 data0_i..data3_i  input  32 each  plaintext block words (CSR AES_D0..D3).
REQ-007 key_addr_i  input  32  byte address of 128-bit key in memory.
REQ-008 mem_req / mem_addr / mem_ack / mem_rdata  out 1 / out 32 / in 1 / in 32  key read port.
REQ-009 core_start  output  1  one-cycle launch pulse to AES core.
REQ-010 core_block / core_key  output  128 each  operands to AES core.
REQ-011 core_done / core_result  input 1 / input 128  core completion pulse and result.
REQ-012 res0_o..res3_o  output  32 each  result words (to CSR AES_Res0..3 inputs).
REQ-013 aes_done / aes_err / busy  output  1 each  completion pulse, abort flag, not-idle.

Function
REQ-014 FSM states: IDLE, FETCH, CORE_GO, CORE_WAIT, DONE; busy = 1 in every state except IDLE.
REQ-015 IDLE: aes_start sampled high latches data0..3 and key_addr_i; aes_start in any other state is ignored, with no queuing.
REQ-016 Key cache: if key_valid=1 and latched key_addr == cached_addr, go IDLE->CORE_GO; otherwise go IDLE->FETCH with word index 0 and clear key_valid.
REQ-017 FETCH: mem_req held 1, mem_addr = {(key_addr + KEY_STRIDE*idx)[31:2],2'b00}; addition is modulo 2^32 (wraps).
REQ-018 mem_addr is stable while mem_req=1 and mem_ack=0; mem_ack outside FETCH is ignored.
REQ-019 On mem_ack sampled: mem_rdata is stored to key word idx, and idx increments; word 0 maps to core_key[127:96], word 3 to [31:0].
REQ-020 On the 4th ack: mem_req deasserts the next cycle, key_valid <= 1, cached_addr <= key_addr, state -> CORE_GO.
REQ-021 Back-to-back acks (ack every cycle) give exactly 4 fetch cycles; mem_req stays high between words.
REQ-022 CORE_GO: core_start = 1 for exactly one cycle, core_block = {d0,d1,d2,d3}, then CORE_WAIT with timeout counter = 0.
REQ-023 core_block and core_key are held constant from CORE_GO until return to IDLE.
REQ-024 CORE_WAIT: on core_done, core_result is captured as res0=[127:96] .. res3=[31:0], and state -> DONE with aes_err=0.
REQ-025 CORE_WAIT without core_done: the counter increments; when counter == CORE_TIMEOUT, state -> DONE with aes_err=1, res0..3 unchanged, key_valid cleared.
REQ-026 core_done on the same edge as counter reaching CORE_TIMEOUT counts as success.
REQ-027 DONE: aes_done = 1 for exactly one cycle, aes_err valid in the same cycle; next state IDLE.
REQ-028 res0..3 hold their value until the next successful completion.
REQ-029 Latency (cached key): aes_start at edge T -> core_start high in cycle T+1; core_done at edge E -> aes_done high in cycle E+1.
REQ-030 aes_err is 0 except in the DONE cycle of an aborted operation.

Reset
REQ-031 nrst low at any time forces IDLE asynchronously, including mid-fetch or mid-core.
REQ-032 During reset: all outputs are 0, res0..3 = 0, key_valid = 0, idx = 0, counter = 0.
REQ-033 An in-flight memory ack or core_done arriving after reset is ignored; no aes_done is produced for an aborted operation.

Verification
REQ-034 Cold start: key_addr=0x100, ack every cycle -> mem_addr 0x100,0x104,0x108,0x10C on consecutive cycles; core_key = those 4 rdata words in order; then one core_start.
REQ-035 Cache hit: repeat with key_addr=0x100 -> no mem_req; core_start in cycle T+1; core_done -> aes_done one cycle later, res0..3 = core_result slices.
REQ-036 Wrap/misalign: key_addr=0xFFFFFFFE -> mem_addr 0xFFFFFFFC,0x00000000,0x00000004,0x00000008.
REQ-037 Timeout: CORE_TIMEOUT=8, core_done never asserted -> aes_done=1 and aes_err=1 after 8 wait cycles; res unchanged; next start with the same address refetches.
REQ-038 Start while busy: pulse aes_start during FETCH with new data -> ignored; the result reflects the original data.
REQ-039 Reset mid-CORE_WAIT, then late core_done -> no aes_done; busy=0; key_valid=0.
